// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit: iterative RV32M multiply/divide unit, radix-2 shift-add and
// restoring divide over XLEN cycles, with divide special-case fast path.
// Revision: 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            iClk,
  input  logic            iRstN,
  input  logic            iStart,
  input  logic [2:0]      iOp,
  input  logic [XLEN-1:0] iA,
  input  logic [XLEN-1:0] iB,
  input  logic            iFlush,
  output logic            oBusy,
  output logic            oDone,
  output logic [XLEN-1:0] oResult
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN:0]   acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              fast_q, fast_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              w_is_div;
  logic              w_a_signed;
  logic              w_b_signed;
  logic              w_a_neg;
  logic              w_b_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic              w_div_zero;
  logic              w_ovf;
  logic [XLEN:0]     w_mul_sum;
  logic [2*XLEN:0]   w_mul_next;
  logic [2*XLEN:0]   w_shift;
  logic [XLEN:0]     w_trial;
  logic [2*XLEN:0]   w_div_next;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fast_res;
  logic [XLEN-1:0]   w_fix_res;

  // Only MULHSU mixes signedness; odd funct3 codes are unsigned except MULH.
  assign w_is_div   = op_q[2];
  assign w_a_signed = ~op_q[0] | (op_q == 3'b001);
  assign w_b_signed = w_a_signed & (op_q != 3'b010);
  assign w_a_neg    = w_a_signed & a_q[XLEN-1];
  assign w_b_neg    = w_b_signed & b_q[XLEN-1];
  assign w_a_mag    = w_a_neg ? -a_q : a_q;
  assign w_b_mag    = w_b_neg ? -b_q : b_q;
  assign w_div_zero = w_is_div & (b_q == '0);
  assign w_ovf      = w_is_div & ~op_q[0] & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);

  // The top accumulator bit is always zero after a multiply shift.
  assign w_mul_sum  = acc_q[2*XLEN:XLEN] + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {1'b0, w_mul_sum, acc_q[XLEN-1:1]};

  assign w_shift    = {acc_q[2*XLEN-1:0], 1'b0};
  assign w_trial    = w_shift[2*XLEN:XLEN] - {1'b0, opnd_q};
  assign w_div_next = w_trial[XLEN] ? w_shift : {w_trial, w_shift[XLEN-1:1], 1'b1};

  assign w_prod_fix = neg_res_q ? -acc_q[2*XLEN-1:0] : acc_q[2*XLEN-1:0];
  assign w_quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign w_rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  always_comb begin
    w_fast_res = '0;
    if (b_q == '0) begin
      w_fast_res = op_q[1] ? a_q : '1;
    end else begin
      w_fast_res = op_q[1] ? '0 : a_q;
    end
  end

  always_comb begin
    w_fix_res = w_rem_fix;
    if (fast_q) begin
      w_fix_res = w_fast_res;
    end else begin
      case (op_q)
        3'b000:                 w_fix_res = w_prod_fix[XLEN-1:0];
        3'b001, 3'b010, 3'b011: w_fix_res = w_prod_fix[2*XLEN-1:XLEN];
        3'b100, 3'b101:         w_fix_res = w_quo_fix;
        default:                w_fix_res = w_rem_fix;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    fast_d    = fast_q;
    result_d  = result_q;
    if (iFlush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            op_d    = iOp;
            a_d     = iA;
            b_d     = iB;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          opnd_d    = w_is_div ? w_b_mag : w_a_mag;
          acc_d     = {{(XLEN+1){1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
          cnt_d     = CW'(XLEN-1);
          neg_res_d = w_a_neg ^ w_b_neg;
          neg_rem_d = w_a_neg;
          fast_d    = w_div_zero | w_ovf;
          // Special cases skip CALC; FIX still registers the result.
          state_d   = (w_div_zero | w_ovf) ? S_FIX : S_CALC;
        end
        S_CALC: begin
          acc_d = w_is_div ? w_div_next : w_mul_next;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end
        end
        S_FIX: begin
          result_d = w_fix_res;
          state_d  = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      fast_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      fast_q    <= fast_d;
      result_q  <= result_d;
    end
  end

  assign oBusy   = (state_q != S_IDLE);
  assign oDone   = (state_q == S_DONE) & ~iFlush;
  assign oResult = result_q;

endmodule

`default_nettype wire
